// File: rtl/psum_exchange_reader.sv
// Read side of the cross-core partial-sum exchange: pops the peer core's sum
// from the async FIFO and adds it to this core's local sum.
module psum_exchange_reader #(
    parameter int bw_psum = 19,
    parameter int sw      = bw_psum + 4,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [sw-1:0] local_sum,
    input  logic          local_sum_vld,
    output logic          local_rdy,
    input  logic          ext_empty,
    output logic          ext_rd,
    input  logic [sw-1:0] ext_data,
    output logic [sw:0]   total_sum,
    output logic          total_vld,
    output logic          timeout_err,
    input  logic          err_clr,
    output logic [7:0]    pair_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_REQ,
        ST_CAP
    } state_t;

    localparam logic [7:0] timer_last = 8'(TIMEOUT - 1);

    state_t        state;
    logic [sw-1:0] local_q;
    logic [7:0]    timer;

    // NOTE: all state is registered with non-blocking assignments so every
    // branch below reads the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            local_q     <= '0;
            timer       <= '0;
            local_rdy   <= 1'b1;
            ext_rd      <= 1'b0;
            total_sum   <= '0;
            total_vld   <= 1'b0;
            timeout_err <= 1'b0;
            pair_cnt    <= '0;
        end else begin
            ext_rd    <= 1'b0;
            total_vld <= 1'b0;
            // A timeout set later in this block overrides the clear.
            if (err_clr)
                timeout_err <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (local_sum_vld) begin
                        local_q   <= local_sum;
                        timer     <= '0;
                        local_rdy <= 1'b0;
                        state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!ext_empty) begin
                        ext_rd <= 1'b1;
                        state  <= ST_REQ;
                    end else if (timer == timer_last) begin
                        timeout_err <= 1'b1;
                        local_q     <= '0;
                        local_rdy   <= 1'b1;
                        state       <= ST_IDLE;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                ST_REQ: begin
                    state <= ST_CAP;
                end
                ST_CAP: begin
                    // Both operands sign-extended by one bit: the sum cannot overflow.
                    total_sum <= {local_q[sw-1], local_q} + {ext_data[sw-1], ext_data};
                    total_vld <= 1'b1;
                    pair_cnt  <= pair_cnt + 8'd1;
                    local_rdy <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_psum_exchange_reader.sv
// Directed bench for psum_exchange_reader: one default instance and one with
// TIMEOUT=8 for the timeout cases.
module tb_psum_exchange_reader;

    localparam int sw = 23;

    logic          clk = 1'b0;
    logic          reset;
    logic [sw-1:0] local_sum;
    logic [sw-1:0] ext_data;
    logic          local_sum_vld, ext_empty, err_clr;
    logic          local_rdy, ext_rd, total_vld, timeout_err;
    logic [sw:0]   total_sum;
    logic [7:0]    pair_cnt;

    logic          local_sum_vld8, ext_empty8, err_clr8;
    logic          local_rdy8, ext_rd8, total_vld8, timeout_err8;
    logic [sw:0]   total_sum8;
    logic [7:0]    pair_cnt8;

    int n_tests = 0;
    int n_fail  = 0;
    int rd_cnt = 0, tv_cnt = 0, rd_cnt8 = 0, tv_cnt8 = 0;
    int rd0, tv0;
    logic [7:0] pc0;

    always #5 clk = ~clk;

    psum_exchange_reader dut (
        .clk(clk), .reset(reset),
        .local_sum(local_sum), .local_sum_vld(local_sum_vld), .local_rdy(local_rdy),
        .ext_empty(ext_empty), .ext_rd(ext_rd), .ext_data(ext_data),
        .total_sum(total_sum), .total_vld(total_vld),
        .timeout_err(timeout_err), .err_clr(err_clr), .pair_cnt(pair_cnt)
    );

    psum_exchange_reader #(.TIMEOUT(8)) dut8 (
        .clk(clk), .reset(reset),
        .local_sum(local_sum), .local_sum_vld(local_sum_vld8), .local_rdy(local_rdy8),
        .ext_empty(ext_empty8), .ext_rd(ext_rd8), .ext_data(ext_data),
        .total_sum(total_sum8), .total_vld(total_vld8),
        .timeout_err(timeout_err8), .err_clr(err_clr8), .pair_cnt(pair_cnt8)
    );

    always @(posedge clk) begin
        if (ext_rd)     rd_cnt  <= rd_cnt + 1;
        if (total_vld)  tv_cnt  <= tv_cnt + 1;
        if (ext_rd8)    rd_cnt8 <= rd_cnt8 + 1;
        if (total_vld8) tv_cnt8 <= tv_cnt8 + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
    endtask

    // One full pair on the default instance with the FIFO already non-empty.
    task automatic run_pair(input string tag, input logic [sw-1:0] l,
                            input logic [sw-1:0] e, input logic [sw:0] exp);
        logic [7:0] pc;
        int rd_start;
        pc = pair_cnt;
        rd_start = rd_cnt;
        local_sum = l;
        ext_data = e;
        ext_empty = 1'b0;
        local_sum_vld = 1'b1;
        step();                                   // t: accepted, now WAIT
        local_sum_vld = 1'b0;
        check({tag, "_rdy_low"}, 32'(local_rdy), 32'd0);
        check({tag, "_rd_wait"}, 32'(ext_rd), 32'd0);
        step();                                   // t+2: REQ
        check({tag, "_rd_req"}, 32'(ext_rd), 32'd1);
        step();                                   // t+3: CAP
        check({tag, "_rd_cap"}, 32'(ext_rd), 32'd0);
        check({tag, "_vld_cap"}, 32'(total_vld), 32'd0);
        step();                                   // t+4: result
        check({tag, "_vld"}, 32'(total_vld), 32'd1);
        check({tag, "_sum"}, 32'(total_sum), 32'(exp));
        check({tag, "_rdy"}, 32'(local_rdy), 32'd1);
        check({tag, "_cnt"}, 32'(pair_cnt), 32'(pc + 8'd1));
        step();
        check({tag, "_vld_drop"}, 32'(total_vld), 32'd0);
        check({tag, "_sum_hold"}, 32'(total_sum), 32'(exp));
        check({tag, "_one_pop"}, 32'(rd_cnt - rd_start), 32'd1);
    endtask

    initial begin
        reset = 1'b1;
        local_sum = '0;
        ext_data = '0;
        local_sum_vld = 1'b0;
        ext_empty = 1'b1;
        err_clr = 1'b0;
        local_sum_vld8 = 1'b0;
        ext_empty8 = 1'b1;
        err_clr8 = 1'b0;
        step(3);
        reset = 1'b0;

        check("rst_rd", 32'(ext_rd), 32'd0);
        check("rst_sum", 32'(total_sum), 32'd0);
        check("rst_vld", 32'(total_vld), 32'd0);
        check("rst_err", 32'(timeout_err), 32'd0);
        check("rst_cnt", 32'(pair_cnt), 32'd0);
        check("rst_rdy", 32'(local_rdy), 32'd1);

        // Basic pair and sign extremes.
        run_pair("basic", 23'h000064, 23'h7FFFCE, 24'h000032);
        run_pair("negmax", 23'h400000, 23'h400000, 24'h800000);
        run_pair("posmax", 23'h3FFFFF, 23'h3FFFFF, 24'h7FFFFE);

        // Late FIFO: 10 empty cycles, vld pulses in WAIT ignored.
        pc0 = pair_cnt;
        rd0 = rd_cnt;
        local_sum = 23'd7;
        ext_data = 23'd3;
        ext_empty = 1'b1;
        local_sum_vld = 1'b1;
        step();
        for (int i = 0; i < 10; i++) begin
            local_sum_vld = (i % 3 == 0);
            local_sum = 23'd1000;
            step();
        end
        local_sum_vld = 1'b0;
        check("late_no_rd", 32'(rd_cnt - rd0), 32'd0);
        check("late_rdy", 32'(local_rdy), 32'd0);
        ext_empty = 1'b0;
        step();
        check("late_rd", 32'(ext_rd), 32'd1);
        step(2);
        check("late_vld", 32'(total_vld), 32'd1);
        check("late_sum", 32'(total_sum), 32'd10);
        check("late_err", 32'(timeout_err), 32'd0);
        step(3);
        check("late_cnt", 32'(pair_cnt), 32'(pc0 + 8'd1));
        check("late_pops", 32'(rd_cnt - rd0), 32'd1);

        // Timeout on the TIMEOUT=8 instance.
        local_sum_vld8 = 1'b1;
        ext_empty8 = 1'b1;
        step();
        local_sum_vld8 = 1'b0;
        step(7);
        check("to_early", 32'(timeout_err8), 32'd0);
        step();
        check("to_err", 32'(timeout_err8), 32'd1);
        check("to_idle", 32'(local_rdy8), 32'd1);
        check("to_no_rd", 32'(rd_cnt8), 32'd0);
        check("to_no_vld", 32'(tv_cnt8), 32'd0);
        check("to_cnt", 32'(pair_cnt8), 32'd0);

        // Second timeout with err_clr in the same cycle: set wins.
        local_sum_vld8 = 1'b1;
        step();
        local_sum_vld8 = 1'b0;
        step(7);
        err_clr8 = 1'b1;
        step();
        err_clr8 = 1'b0;
        check("to_set_wins", 32'(timeout_err8), 32'd1);
        err_clr8 = 1'b1;
        step();
        err_clr8 = 1'b0;
        check("to_clr", 32'(timeout_err8), 32'd0);

        // FIFO goes non-empty on the final timeout cycle: pair proceeds.
        local_sum = 23'h7FFFFF;
        ext_data = 23'd2;
        local_sum_vld8 = 1'b1;
        step();
        local_sum_vld8 = 1'b0;
        step(7);
        ext_empty8 = 1'b0;
        step();
        check("edge_rd", 32'(ext_rd8), 32'd1);
        check("edge_no_err", 32'(timeout_err8), 32'd0);
        step(2);
        check("edge_vld", 32'(total_vld8), 32'd1);
        check("edge_sum", 32'(total_sum8), 32'd1);
        check("edge_cnt", 32'(pair_cnt8), 32'd1);
        ext_empty8 = 1'b1;

        // Back-to-back: 300 pairs, vld held high.
        do_reset();
        rd0 = rd_cnt;
        tv0 = tv_cnt;
        local_sum = 23'd5;
        ext_data = 23'h7FFFF9;
        ext_empty = 1'b0;
        local_sum_vld = 1'b1;
        step(1200);
        check("b2b_vld_last", 32'(total_vld), 32'd1);
        local_sum_vld = 1'b0;
        step();
        check("b2b_rd_cnt", 32'(rd_cnt - rd0), 32'd300);
        check("b2b_vld_cnt", 32'(tv_cnt - tv0), 32'd300);
        check("b2b_pair_cnt", 32'(pair_cnt), 32'd44);
        check("b2b_sum", 32'(total_sum), 32'h00FFFFFE);

        // Reset during CAP aborts the pair.
        pc0 = pair_cnt;
        tv0 = tv_cnt;
        local_sum_vld = 1'b1;
        step();
        local_sum_vld = 1'b0;
        step(2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rcap_vld", 32'(total_vld), 32'd0);
        check("rcap_rdy", 32'(local_rdy), 32'd1);
        check("rcap_rd", 32'(ext_rd), 32'd0);
        step();
        check("rcap_no_vld", 32'(tv_cnt - tv0), 32'd0);
        check("rcap_cnt", 32'(pair_cnt), 32'd0);
        check("rcap_still_idle", 32'(local_rdy), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
